// File: rtl/md5_block_engine.sv
`default_nettype none
// ============================================================================
// Module      : md5_block_engine
// Description : Iterative MD5 compression core. Accepts one padded 512-bit
//               block, performs one round per clock using an external
//               combinational sine-constant table, and updates the 128-bit
//               chaining state.
// Revision    : 1.0 - initial release
// ============================================================================
module md5_block_engine #(
    parameter logic [31:0] IV_A = 32'h67452301,
    parameter logic [31:0] IV_B = 32'hefcdab89,
    parameter logic [31:0] IV_C = 32'h98badcfe,
    parameter logic [31:0] IV_D = 32'h10325476
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic [5:0]   sint_index,
    input  logic [31:0]  sint_data,
    output logic         digest_valid,
    output logic [127:0] digest
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    // Rotate amounts indexed by {quarter, round[1:0]}
    localparam logic [4:0] C_S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    state_t       r_state;
    state_t       w_state_nxt;
    logic [5:0]   r_rnd;
    logic [31:0]  r_ha, r_hb, r_hc, r_hd;
    logic [31:0]  r_a, r_b, r_c, r_d;
    logic [31:0]  r_m [16];
    logic [127:0] r_digest;
    logic         r_digest_valid;

    logic         w_accept;
    logic [31:0]  w_sel_a, w_sel_b, w_sel_c, w_sel_d;
    logic [31:0]  w_f, w_sum, w_rot, w_new_b;
    logic [31:0]  w_sum_a, w_sum_b, w_sum_c, w_sum_d;
    logic [3:0]   w_i4, w_g;
    logic [4:0]   w_s;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign blk_ready    = rst_n & (r_state == ST_IDLE);
    assign w_accept     = blk_valid & blk_ready;
    assign sint_index   = r_rnd;
    assign digest_valid = r_digest_valid;
    assign digest       = r_digest;

    // A new message chains from the IV, a continuation from the stored state
    assign w_sel_a = blk_first ? IV_A : r_ha;
    assign w_sel_b = blk_first ? IV_B : r_hb;
    assign w_sel_c = blk_first ? IV_C : r_hc;
    assign w_sel_d = blk_first ? IV_D : r_hd;

    assign w_sum_a = r_ha + r_a;
    assign w_sum_b = r_hb + r_b;
    assign w_sum_c = r_hc + r_c;
    assign w_sum_d = r_hd + r_d;

    // Round function, message word selection and rotate for the current round
    always_comb begin
        w_i4 = r_rnd[3:0];
        w_f  = '0;
        w_g  = '0;
        case (r_rnd[5:4])
            2'd0: begin
                w_f = (r_b & r_c) | (~r_b & r_d);
                w_g = w_i4;
            end
            2'd1: begin
                w_f = (r_d & r_b) | (~r_d & r_c);
                w_g = w_i4 * 4'd5 + 4'd1;
            end
            2'd2: begin
                w_f = r_b ^ r_c ^ r_d;
                w_g = w_i4 * 4'd3 + 4'd5;
            end
            default: begin
                w_f = r_c ^ (r_b | ~r_d);
                w_g = w_i4 * 4'd7;
            end
        endcase
        w_s     = C_S_TAB[{r_rnd[5:4], r_rnd[1:0]}];
        w_sum   = r_a + w_f + sint_data + r_m[w_g];
        // Shift amount is never zero, so the complementary shift stays below 32
        w_rot   = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
        w_new_b = r_b + w_rot;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ROUND;
            ST_ROUND: if (r_rnd == 6'd63) w_state_nxt = ST_FINAL;
            ST_FINAL: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Message words are latched little-endian on accept; no reset needed
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_accept) begin
            for (int k = 0; k < 16; k++) begin
                r_m[k] <= bswap(blk_data[511-32*k -: 32]);
            end
        end
    end

    // Chaining state, working registers, round counter and digest output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rnd          <= '0;
            r_ha           <= IV_A;
            r_hb           <= IV_B;
            r_hc           <= IV_C;
            r_hd           <= IV_D;
            r_a            <= '0;
            r_b            <= '0;
            r_c            <= '0;
            r_d            <= '0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ha  <= w_sel_a;
                        r_hb  <= w_sel_b;
                        r_hc  <= w_sel_c;
                        r_hd  <= w_sel_d;
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_c   <= w_sel_c;
                        r_d   <= w_sel_d;
                        r_rnd <= '0;
                    end
                end
                ST_ROUND: begin
                    r_a   <= r_d;
                    r_b   <= w_new_b;
                    r_c   <= r_b;
                    r_d   <= r_c;
                    r_rnd <= r_rnd + 6'd1;
                end
                ST_FINAL: begin
                    r_ha           <= w_sum_a;
                    r_hb           <= w_sum_b;
                    r_hc           <= w_sum_c;
                    r_hd           <= w_sum_d;
                    r_digest       <= {bswap(w_sum_a), bswap(w_sum_b),
                                       bswap(w_sum_c), bswap(w_sum_d)};
                    r_digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md5_block_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_md5_block_engine
// Description : Directed bench for md5_block_engine using known MD5 digests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md5_block_engine;

    localparam logic [31:0] T_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [511:0] C_ABC   = {24'h616263, 8'h80, 416'h0, 8'h18, 56'h0};
    localparam logic [127:0] C_D_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [511:0] C_BLK1  =
        "1234567890123456789012345678901234567890123456789012345678901234";
    localparam logic [511:0] C_BLK2  =
        {"5678901234567890", 8'h80, 312'h0, 8'h80, 8'h02, 48'h0};
    localparam logic [127:0] C_D_80  = 128'h57edf4a22be3c955ac49da2e2107b67a;

    typedef struct {
        logic [511:0] data;
        logic [127:0] exp;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic [5:0]   sint_index;
    logic [31:0]  sint_data;
    logic         digest_valid;
    logic [127:0] digest;

    int n_checks;
    int n_fail;

    md5_block_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_first    (blk_first),
        .sint_index   (sint_index),
        .sint_data    (sint_data),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    // Combinational sine-constant table
    assign sint_data = T_TAB[sint_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and wait for it to be accepted (blk_valid dropped afterwards)
    task automatic offer(input logic [511:0] data, input logic first);
        int cnt;
        blk_data  = data;
        blk_first = first;
        blk_valid = 1'b1;
        cnt = 0;
        while (!blk_ready && cnt < 200) begin
            step();
            cnt++;
        end
        chk("accept_timeout", 128'(cnt < 200), 128'(1));
        step();
        blk_valid = 1'b0;
    endtask

    // Count edges after the accept edge until digest_valid rises
    task automatic wait_digest(output int lat);
        lat = 1;
        step();
        while (!digest_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    // Count digest_valid pulses over a window
    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (digest_valid) pulses++;
        end
    endtask

    task automatic run_block(input string name, input logic [511:0] data,
                             input logic first, input logic [127:0] exp);
        int lat;
        offer(data, first);
        wait_digest(lat);
        chk({name, "_latency"}, 128'(lat), 128'(65));
        chk({name, "_digest"}, digest, exp);
        chk({name, "_ready_at_valid"}, 128'(blk_ready), 128'(1));
        step();
        chk({name, "_valid_pulse"}, 128'(digest_valid), 128'(0));
        chk({name, "_digest_hold"}, digest, exp);
    endtask

    task automatic run_two_block(input string name);
        int lat;
        blk_data  = C_BLK1;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        lat = 0;
        while (!blk_ready && lat < 200) begin
            step();
            lat++;
        end
        step();
        // Present block 2 right away; blk_valid stays high throughout
        blk_data  = C_BLK2;
        blk_first = 1'b0;
        wait_digest(lat);
        chk({name, "_b1_latency"}, 128'(lat), 128'(65));
        chk({name, "_b1_ready"}, 128'(blk_ready), 128'(1));
        step();
        chk({name, "_b2_accepted"}, 128'(blk_ready), 128'(0));
        chk({name, "_b1_pulse"}, 128'(digest_valid), 128'(0));
        blk_valid = 1'b0;
        wait_digest(lat);
        chk({name, "_b2_latency"}, 128'(lat), 128'(65));
        chk({name, "_digest"}, digest, C_D_80);
        step();
    endtask

    initial begin
        vec_t vecs [5];
        int   lat;
        int   pulses;

        vecs[0].data = {8'h80, 504'h0};
        vecs[0].exp  = 128'hd41d8cd98f00b204e9800998ecf8427e;
        vecs[1].data = {8'h61, 8'h80, 432'h0, 8'h08, 56'h0};
        vecs[1].exp  = 128'h0cc175b9c0f1b6a831c399e269772661;
        vecs[2].data = C_ABC;
        vecs[2].exp  = C_D_ABC;
        vecs[3].data = {"message digest", 8'h80, 328'h0, 8'h70, 56'h0};
        vecs[3].exp  = 128'hf96b697d7cb7938d525a2f31aaf161d0;
        vecs[4].data = {"abcdefghijklmnopqrstuvwxyz", 8'h80, 232'h0, 8'hd0, 56'h0};
        vecs[4].exp  = 128'hc3fcd3d76192e4007dfb496cca67e13b;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_data  = '0;

        // Reset state
        step();
        step();
        chk("rst_ready", 128'(blk_ready), 128'(0));
        chk("rst_digest", digest, 128'h0);
        chk("rst_valid", 128'(digest_valid), 128'(0));
        chk("rst_index", 128'(sint_index), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("idle_ready", 128'(blk_ready), 128'(1));

        // Known single-block messages
        for (int v = 0; v < 5; v++) begin
            run_block($sformatf("vec%0d", v), vecs[v].data, 1'b1, vecs[v].exp);
        end

        // Two-block message, back to back, then repeated to confirm IV restart
        run_two_block("two_blk");
        run_two_block("two_blk_again");
        run_block("abc_after_chain", C_ABC, 1'b1, C_D_ABC);

        // Round index trace with a stray blk_valid pulse mid-round
        offer(C_ABC, 1'b1);
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("trace_index%0d", k), 128'(sint_index), 128'(k));
            chk($sformatf("trace_ready%0d", k), 128'(blk_ready), 128'(0));
            if (k == 10) begin
                blk_data  = {8'h80, 504'h0};
                blk_valid = 1'b1;
            end
            if (k == 11) blk_valid = 1'b0;
            step();
        end
        chk("trace_no_early_valid", 128'(digest_valid), 128'(0));
        step();
        chk("trace_valid", 128'(digest_valid), 128'(1));
        chk("trace_digest", digest, C_D_ABC);
        count_pulses(80, pulses);
        chk("trace_no_extra_block", 128'(pulses), 128'(0));

        // Reset during round 30 discards the block
        offer(C_ABC, 1'b1);
        for (int k = 0; k < 30; k++) step();
        chk("mid_index", 128'(sint_index), 128'(30));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(blk_ready), 128'(0));
        step();
        chk("mid_rst_digest", digest, 128'h0);
        chk("mid_rst_index", 128'(sint_index), 128'(0));
        chk("mid_rst_valid", 128'(digest_valid), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("mid_rst_idle", 128'(blk_ready), 128'(1));
        count_pulses(80, pulses);
        chk("mid_rst_no_pulse", 128'(pulses), 128'(0));
        run_block("abc_after_reset", C_ABC, 1'b1, C_D_ABC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
